// File: rtl/rob_queue.sv
// In-order reorder buffer: allocates tags, captures ALU writeback, broadcasts entry state and
// retires completed entries in program order. Entry i always owns tag i.
module rob_queue #(
    parameter int unsigned ENTRY_NUM = 8,
    parameter int unsigned TAG_W     = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned REG_W     = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        alloc_req,
    input  logic [REG_W-1:0]            alloc_dest,
    output logic [TAG_W-1:0]            alloc_tag,
    output logic                        full,
    input  logic [TAG_W-1:0]            wb_target,
    input  logic [DATA_W-1:0]           wb_result,
    output logic [ENTRY_NUM-1:0]        bc_valid,
    output logic [ENTRY_NUM-1:0]        bc_ready,
    output logic [ENTRY_NUM*TAG_W-1:0]  bc_tag,
    output logic [ENTRY_NUM*DATA_W-1:0] bc_val,
    output logic                        commit_en,
    output logic [REG_W-1:0]            commit_reg,
    output logic [DATA_W-1:0]           commit_val
);

    localparam int unsigned PTR_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;
    localparam int unsigned CNT_W = $clog2(ENTRY_NUM + 1);
    localparam logic [TAG_W-1:0] TAG_INVALID = {TAG_W{1'b1}};

    logic [ENTRY_NUM-1:0] valid_q;
    logic [ENTRY_NUM-1:0] ready_q;
    logic [REG_W-1:0]     dest_q [ENTRY_NUM];
    logic [DATA_W-1:0]    val_q  [ENTRY_NUM];
    logic [PTR_W-1:0]     head_q;
    logic [PTR_W-1:0]     tail_q;
    logic [CNT_W-1:0]     count_q;

    logic             do_alloc;
    logic             do_wb;
    logic             do_commit;
    logic [PTR_W-1:0] wb_idx;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == ENTRY_NUM - 1) ? '0 : p + 1'b1;
    endfunction

    assign full      = (32'(count_q) == ENTRY_NUM);
    assign alloc_tag = full ? TAG_INVALID : TAG_W'(tail_q);
    assign wb_idx    = wb_target[PTR_W-1:0];

    // All decisions use pre-edge state, so an entry allocated this cycle cannot take a writeback
    // and the head being written back retires one cycle later.
    always_comb begin
        do_commit = valid_q[head_q] && ready_q[head_q];
        do_alloc  = alloc_req && !full;
        do_wb     = (wb_target != TAG_INVALID) && (32'(wb_target) < ENTRY_NUM) &&
                    valid_q[wb_idx] && !ready_q[wb_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= '0;
            ready_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            commit_en  <= 1'b0;
            commit_reg <= '0;
            commit_val <= '0;
            for (int i = 0; i < int'(ENTRY_NUM); i++) begin
                dest_q[i] <= '0;
                val_q[i]  <= '0;
            end
        end else if (flush) begin
            // commit_reg/commit_val deliberately hold across a flush
            valid_q   <= '0;
            ready_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            commit_en <= 1'b0;
            for (int i = 0; i < int'(ENTRY_NUM); i++) begin
                dest_q[i] <= '0;
                val_q[i]  <= '0;
            end
        end else begin
            commit_en <= do_commit;
            if (do_commit) begin
                commit_reg      <= dest_q[head_q];
                commit_val      <= val_q[head_q];
                valid_q[head_q] <= 1'b0;
                ready_q[head_q] <= 1'b0;
                val_q[head_q]   <= '0;
                head_q          <= ptr_inc(head_q);
            end
            if (do_wb) begin
                val_q[wb_idx]   <= wb_result;
                ready_q[wb_idx] <= 1'b1;
            end
            if (do_alloc) begin
                valid_q[tail_q] <= 1'b1;
                ready_q[tail_q] <= 1'b0;
                dest_q[tail_q]  <= alloc_dest;
                val_q[tail_q]   <= '0;
                tail_q          <= ptr_inc(tail_q);
            end
            count_q <= count_q + CNT_W'(do_alloc) - CNT_W'(do_commit);
        end
    end

    assign bc_valid = valid_q;
    assign bc_ready = ready_q;

    for (genvar i = 0; i < int'(ENTRY_NUM); i++) begin : g_bc
        assign bc_tag[i*TAG_W +: TAG_W]   = TAG_W'(i);
        assign bc_val[i*DATA_W +: DATA_W] = val_q[i];
    end

endmodule

// File: tb/tb_rob_queue.sv
// Bench for rob_queue: directed vector table, hand-written corner sequences and randomized
// traffic checked against a simple array model of the reorder buffer.
module tb_rob_queue;

    localparam int N  = 8;
    localparam int TW = 4;
    localparam int DW = 32;
    localparam int RW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            alloc_req;
    logic [RW-1:0]   alloc_dest;
    logic [TW-1:0]   alloc_tag;
    logic            full;
    logic [TW-1:0]   wb_target;
    logic [DW-1:0]   wb_result;
    logic [N-1:0]    bc_valid;
    logic [N-1:0]    bc_ready;
    logic [N*TW-1:0] bc_tag;
    logic [N*DW-1:0] bc_val;
    logic            commit_en;
    logic [RW-1:0]   commit_reg;
    logic [DW-1:0]   commit_val;

    rob_queue #(.ENTRY_NUM(N), .TAG_W(TW), .DATA_W(DW), .REG_W(RW)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .alloc_req  (alloc_req),
        .alloc_dest (alloc_dest),
        .alloc_tag  (alloc_tag),
        .full       (full),
        .wb_target  (wb_target),
        .wb_result  (wb_result),
        .bc_valid   (bc_valid),
        .bc_ready   (bc_ready),
        .bc_tag     (bc_tag),
        .bc_val     (bc_val),
        .commit_en  (commit_en),
        .commit_reg (commit_reg),
        .commit_val (commit_val)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: entries as plain arrays, occupancy as head + count.
    bit            m_valid [N];
    bit            m_ready [N];
    logic [RW-1:0] m_dest  [N];
    logic [DW-1:0] m_val   [N];
    int            m_head;
    int            m_count;
    bit            m_cen;
    logic [RW-1:0] m_creg;
    logic [DW-1:0] m_cval;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_ready[i] = 1'b0;
            m_dest[i]  = '0;
            m_val[i]   = '0;
        end
        m_head  = 0;
        m_count = 0;
        m_cen   = 1'b0;
    endtask

    task automatic model_reset();
        model_clear();
        m_creg = '0;
        m_cval = '0;
    endtask

    task automatic model_step(input bit fl, input bit req, input logic [RW-1:0] dest,
                              input logic [TW-1:0] tgt, input logic [DW-1:0] res);
        int  tail;
        bit  com;
        bit  al;
        bit  wb;
        if (fl) begin
            model_clear();
            return;
        end
        tail = (m_head + m_count) % N;
        com  = m_valid[m_head] && m_ready[m_head];
        al   = req && (m_count != N);
        wb   = (int'(tgt) < N) && m_valid[int'(tgt)] && !m_ready[int'(tgt)];
        m_cen = com;
        if (com) begin
            m_creg = m_dest[m_head];
            m_cval = m_val[m_head];
            m_valid[m_head] = 1'b0;
            m_ready[m_head] = 1'b0;
            m_val[m_head]   = '0;
            m_head = (m_head + 1) % N;
        end
        if (wb) begin
            m_val[int'(tgt)]   = res;
            m_ready[int'(tgt)] = 1'b1;
        end
        if (al) begin
            m_valid[tail] = 1'b1;
            m_ready[tail] = 1'b0;
            m_dest[tail]  = dest;
            m_val[tail]   = '0;
        end
        m_count = m_count + int'(al) - int'(com);
    endtask

    task automatic check_model(input string tag);
        logic [N-1:0]    ev;
        logic [N-1:0]    er;
        logic [N*DW-1:0] eval;
        logic [TW-1:0]   etag;
        for (int i = 0; i < N; i++) begin
            ev[i] = m_valid[i];
            er[i] = m_ready[i];
            eval[i*DW +: DW] = m_val[i];
        end
        etag = (m_count == N) ? 4'hF : TW'((m_head + m_count) % N);
        chk({tag, ".bc_valid"}, 256'(bc_valid), 256'(ev));
        chk({tag, ".bc_ready"}, 256'(bc_ready), 256'(er));
        chk({tag, ".bc_val"}, 256'(bc_val), 256'(eval));
        chk({tag, ".commit_en"}, 256'(commit_en), 256'(m_cen));
        chk({tag, ".commit_reg"}, 256'(commit_reg), 256'(m_creg));
        chk({tag, ".commit_val"}, 256'(commit_val), 256'(m_cval));
        chk({tag, ".full"}, 256'(full), 256'(m_count == N));
        chk({tag, ".alloc_tag"}, 256'(alloc_tag), 256'(etag));
    endtask

    // Drive at negedge, let one posedge happen, return at the following negedge.
    task automatic step(input bit fl, input bit req, input logic [RW-1:0] dest,
                        input logic [TW-1:0] tgt, input logic [DW-1:0] res);
        flush      = fl;
        alloc_req  = req;
        alloc_dest = dest;
        wb_target  = tgt;
        wb_result  = res;
        @(posedge clk);
        model_step(fl, req, dest, tgt, res);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, 4'hF, '0);
    endtask

    typedef struct {
        bit            fl;
        bit            req;
        logic [RW-1:0] dest;
        logic [TW-1:0] tgt;
        logic [DW-1:0] res;
        logic [TW-1:0] e_tag;
        bit            e_full;
        logic [N-1:0]  e_valid;
        logic [N-1:0]  e_ready;
        bit            e_cen;
        logic [RW-1:0] e_creg;
        logic [DW-1:0] e_cval;
    } vec_t;

    vec_t vecs [13];
    logic [N*TW-1:0] exp_bc_tag;

    initial begin
        // Expected values are the state just after the edge that consumes each row.
        vecs[0]  = '{1'b0, 1'b1, 5'd1, 4'hF, 32'h0,  4'd1, 1'b0, 8'h01, 8'h00, 1'b0, 5'd0, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 5'd2, 4'hF, 32'h0,  4'd2, 1'b0, 8'h03, 8'h00, 1'b0, 5'd0, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 5'd3, 4'hF, 32'h0,  4'd3, 1'b0, 8'h07, 8'h00, 1'b0, 5'd0, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 5'd0, 4'd1, 32'h55, 4'd3, 1'b0, 8'h07, 8'h02, 1'b0, 5'd0, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, 5'd0, 4'd0, 32'h11, 4'd3, 1'b0, 8'h07, 8'h03, 1'b0, 5'd0, 32'h0};
        vecs[5]  = '{1'b0, 1'b0, 5'd0, 4'hF, 32'h0,  4'd3, 1'b0, 8'h06, 8'h02, 1'b1, 5'd1, 32'h11};
        vecs[6]  = '{1'b0, 1'b0, 5'd0, 4'hF, 32'h0,  4'd3, 1'b0, 8'h04, 8'h00, 1'b1, 5'd2, 32'h55};
        vecs[7]  = '{1'b0, 1'b0, 5'd0, 4'hF, 32'h0,  4'd3, 1'b0, 8'h04, 8'h00, 1'b0, 5'd2, 32'h55};
        vecs[8]  = '{1'b0, 1'b0, 5'd0, 4'd5, 32'h99, 4'd3, 1'b0, 8'h04, 8'h00, 1'b0, 5'd2, 32'h55};
        vecs[9]  = '{1'b0, 1'b0, 5'd0, 4'hF, 32'h77, 4'd3, 1'b0, 8'h04, 8'h00, 1'b0, 5'd2, 32'h55};
        vecs[10] = '{1'b0, 1'b0, 5'd0, 4'd2, 32'h22, 4'd3, 1'b0, 8'h04, 8'h04, 1'b0, 5'd2, 32'h55};
        vecs[11] = '{1'b0, 1'b0, 5'd0, 4'd2, 32'h33, 4'd3, 1'b0, 8'h00, 8'h00, 1'b1, 5'd3, 32'h22};
        vecs[12] = '{1'b0, 1'b0, 5'd0, 4'd9, 32'h44, 4'd3, 1'b0, 8'h00, 8'h00, 1'b0, 5'd3, 32'h22};

        rst = 1'b1;
        flush = 1'b0;
        alloc_req = 1'b0;
        alloc_dest = '0;
        wb_target = 4'hF;
        wb_result = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_model("reset");
        for (int i = 0; i < N; i++) exp_bc_tag[i*TW +: TW] = TW'(i);
        chk("bc_tag", 256'(bc_tag), 256'(exp_bc_tag));
        rst = 1'b0;

        // Directed table: allocation, out-of-order writeback, in-order commit, ignored writebacks
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].fl, vecs[i].req, vecs[i].dest, vecs[i].tgt, vecs[i].res);
            chk($sformatf("vec%0d.alloc_tag", i), 256'(alloc_tag), 256'(vecs[i].e_tag));
            chk($sformatf("vec%0d.full", i), 256'(full), 256'(vecs[i].e_full));
            chk($sformatf("vec%0d.bc_valid", i), 256'(bc_valid), 256'(vecs[i].e_valid));
            chk($sformatf("vec%0d.bc_ready", i), 256'(bc_ready), 256'(vecs[i].e_ready));
            chk($sformatf("vec%0d.commit_en", i), 256'(commit_en), 256'(vecs[i].e_cen));
            chk($sformatf("vec%0d.commit_reg", i), 256'(commit_reg), 256'(vecs[i].e_creg));
            chk($sformatf("vec%0d.commit_val", i), 256'(commit_val), 256'(vecs[i].e_cval));
            check_model($sformatf("vec%0d", i));
        end

        // Fill to full, refused alloc while committing, then wrap to tag 0
        step(1'b1, 1'b0, '0, 4'hF, '0);
        chk("fill.start_tag", 256'(alloc_tag), 256'(4'd0));
        for (int i = 0; i < N; i++) step(1'b0, 1'b1, RW'(i + 8), 4'hF, '0);
        chk("fill.full", 256'(full), 256'(1'b1));
        chk("fill.alloc_tag", 256'(alloc_tag), 256'(4'hF));
        chk("fill.valid", 256'(bc_valid), 256'(8'hFF));
        step(1'b0, 1'b1, 5'd20, 4'd0, 32'hAA);
        chk("fill.refused_valid", 256'(bc_valid), 256'(8'hFF));
        chk("fill.head_ready", 256'(bc_ready), 256'(8'h01));
        step(1'b0, 1'b1, 5'd21, 4'hF, '0);
        chk("fill.commit_en", 256'(commit_en), 256'(1'b1));
        chk("fill.commit_val", 256'(commit_val), 256'(32'hAA));
        chk("fill.commit_reg", 256'(commit_reg), 256'(5'd8));
        chk("fill.alloc_refused", 256'(bc_valid), 256'(8'hFE));
        chk("fill.wrap_tag", 256'(alloc_tag), 256'(4'd0));
        check_model("fill");
        step(1'b0, 1'b1, 5'd30, 4'hF, '0);
        chk("fill.regrant", 256'(bc_valid), 256'(8'hFF));
        check_model("fill.regrant");

        // Flush with live entries, a pending commit and a simultaneous writeback
        step(1'b1, 1'b0, '0, 4'hF, '0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, RW'(i + 1), 4'hF, '0);
        step(1'b0, 1'b0, '0, 4'd0, 32'h10);
        step(1'b1, 1'b1, 5'd9, 4'd2, 32'h20);
        chk("flush.valid", 256'(bc_valid), 256'(8'h00));
        chk("flush.commit_en", 256'(commit_en), 256'(1'b0));
        chk("flush.alloc_tag", 256'(alloc_tag), 256'(4'd0));
        chk("flush.commit_reg_hold", 256'(commit_reg), 256'(5'd8));
        check_model("flush");
        step(1'b0, 1'b1, 5'd7, 4'hF, '0);
        chk("flush.next_alloc", 256'(bc_valid), 256'(8'h01));
        check_model("flush.next");

        // Asynchronous reset between edges while commits are in flight
        step(1'b0, 1'b1, 5'd11, 4'hF, '0);
        step(1'b0, 1'b1, 5'd12, 4'd0, 32'h31);
        step(1'b0, 1'b0, '0, 4'd1, 32'h32);
        chk("arst.pre_commit", 256'(commit_en), 256'(1'b1));
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("arst.commit_en", 256'(commit_en), 256'(1'b0));
        chk("arst.commit_reg", 256'(commit_reg), 256'(5'd0));
        chk("arst.valid", 256'(bc_valid), 256'(8'h00));
        check_model("arst");
        #1 rst = 1'b0;
        idle();
        chk("arst.no_commit", 256'(commit_en), 256'(1'b0));
        check_model("arst.after");

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            bit            fl;
            bit            req;
            logic [TW-1:0] tgt;
            fl  = ($urandom_range(0, 39) == 0);
            req = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 9) < 8)
                tgt = TW'((m_head + $urandom_range(0, 3)) % N);
            else
                tgt = TW'($urandom_range(8, 15));
            step(fl, req, RW'($urandom), tgt, $urandom);
            check_model($sformatf("rand%0d", c));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
